// File: rtl/scan_mux_pkg.sv
// Shared constants and width helper for the scan_mux time-multiplexing selector.
// Optional per-channel blanking is enabled with the SCAN_MUX_BLANK_EN macro.
package scan_mux_pkg;

  localparam int BIT_DEFAULT = 4;
  localparam int N_DEFAULT   = 4;
  localparam int DIV_DEFAULT = 100000;

  // Index width that stays at least one bit wide, so that N=1 or DIV=1 still get a real register.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_mux_if.sv
// Channel bus of scan_mux: scan enable, flattened channel inputs and the registered outputs.
// SCAN_MUX_BLANK_EN adds the per-channel blank input.
interface scan_mux_if
  import scan_mux_pkg::*;
#(
  parameter int BIT = BIT_DEFAULT,
  parameter int N   = N_DEFAULT
);
  localparam int CW = cw(N);

  logic              en;
  logic [N*BIT-1:0]  in;
  logic [BIT-1:0]    out;
  logic [CW-1:0]     sel;
  logic [N-1:0]      an_n;
  logic              slot_end;
`ifdef SCAN_MUX_BLANK_EN
  logic [N-1:0]      blank;

  modport master (output en, in, blank, input out, sel, an_n, slot_end);
  modport slave  (input en, in, blank, output out, sel, an_n, slot_end);
`else
  modport master (output en, in, input out, sel, an_n, slot_end);
  modport slave  (input en, in, output out, sel, an_n, slot_end);
`endif

endinterface

// File: rtl/scan_mux_tick_gen.sv
// Free-running prescaler: raises tick on the enabled cycle that closes each DIV-cycle slot.
module tick_gen
  import scan_mux_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int              CNTW = cw(DIV);
  localparam logic [CNTW-1:0] LAST = CNTW'(DIV - 1);

  logic [CNTW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scan_mux.sv
// N-channel scanning selector: holds the channel index, muxes the selected channel and registers outputs.
// SCAN_MUX_BLANK_EN adds per-channel blanking through the interface blank input.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int BIT = BIT_DEFAULT,
  parameter int N   = N_DEFAULT,
  parameter int DIV = DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  scan_mux_if.slave   bus
);
  localparam int            CW       = cw(N);
  localparam logic [CW-1:0] LAST_SEL = CW'(N - 1);

  logic           tick;
  logic [CW-1:0]  sel_q;
  logic [CW-1:0]  sel_next;
  logic [BIT-1:0] out_d;
  logic [BIT-1:0] out_q;
  logic [N-1:0]   an_d;
  logic [N-1:0]   an_q;
  logic           slot_q;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .tick (tick)
  );

  // Explicit wrap keeps a non-power-of-2 N from ever reaching an unused index.
  assign sel_next = tick ? ((sel_q == LAST_SEL) ? '0 : sel_q + 1'b1) : sel_q;

  // Output registers are fed from sel_next so out, an_n and sel always describe the same channel.
  always_comb begin
    // NOTE: defaults first so no path through the loop leaves out_d/an_d unassigned (no latch).
    out_d = '0;
    an_d  = '1;
    for (int k = 0; k < N; k++) begin
      if (sel_next == CW'(k)) begin
        out_d   = bus.in[k*BIT +: BIT];
        an_d[k] = 1'b0;
`ifdef SCAN_MUX_BLANK_EN
        if (bus.blank[k]) begin
          out_d = '0;
          an_d  = '1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= '0;
      out_q  <= '0;
      an_q   <= '1;
      slot_q <= 1'b0;
    end else begin
      sel_q  <= sel_next;
      out_q  <= out_d;
      an_q   <= an_d;
      slot_q <= tick;
    end
  end

  assign bus.sel      = sel_q;
  assign bus.out      = out_q;
  assign bus.an_n     = an_q;
  assign bus.slot_end = slot_q;

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux (BIT=4, N=3, DIV=4): enabled-cycle model plus directed literal checks.
// Define SCAN_MUX_BLANK_EN to include the blanking scenario.
module tb_scan_mux;
  import scan_mux_pkg::*;

  localparam int BIT = 4;
  localparam int N   = 3;
  localparam int DIV = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  scan_mux_if #(.BIT(BIT), .N(N)) bus ();

  scan_mux #(.BIT(BIT), .N(N), .DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: count enabled cycles since reset; the channel is that count divided into DIV-long slots, mod N.
  int           m_phase;
  bit           m_valid;
  int           e_sel;
  logic [BIT-1:0] e_out;
  logic [N-1:0] e_an;
  logic         e_slot;

  always @(posedge clk) begin
    logic [N-1:0] one;
    bit           tick;
    int           s;
    one = 1;
    if (rst) begin
      m_phase = 0;
      m_valid = 1'b1;
      e_sel   = 0;
      e_out   = '0;
      e_an    = '1;
      e_slot  = 1'b0;
    end else if (m_valid) begin
      tick = bus.en && ((m_phase % DIV) == DIV - 1);
      if (bus.en) m_phase++;
      s      = (m_phase / DIV) % N;
      e_sel  = s;
      e_out  = bus.in[s*BIT +: BIT];
      e_an   = ~(one << s);
      e_slot = tick;
`ifdef SCAN_MUX_BLANK_EN
      if (bus.blank[s]) begin
        e_out = '0;
        e_an  = '1;
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_sel", bus.sel, e_sel);
      check("model_out", bus.out, e_out);
      check("model_an_n", bus.an_n, e_an);
      check("model_slot_end", bus.slot_end, e_slot);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    int hits;
    rst = 1'b1;
    bus.en = 1'b1;
    bus.in = {4'hC, 4'hB, 4'hA};
`ifdef SCAN_MUX_BLANK_EN
    bus.blank = '0;
`endif
    n_cmp = 0;
    n_bad = 0;

    // Reset and start-up
    repeat (2) @(negedge clk);
    check("rst_out", bus.out, 4'h0);
    check("rst_an_n", bus.an_n, 3'b111);
    check("rst_slot_end", bus.slot_end, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("start_out", bus.out, 4'hA);
    check("start_an_n", bus.an_n, 3'b110);

    // Twelve enabled cycles: three slot boundaries, index wraps back to 0
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.slot_end) pulses++;
    end
    check("scan_pulses", pulses, 3);
    check("scan_wrap_sel", bus.sel, 0);

    // Freeze mid-slot (prescaler at 2 of 4)
    @(negedge clk);
    bus.en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("freeze_sel", bus.sel, 0);
      check("freeze_an_n", bus.an_n, 3'b110);
      check("freeze_slot_end", bus.slot_end, 1'b0);
    end
    bus.en = 1'b1;
    @(negedge clk);
    check("resume_sel_hold", bus.sel, 0);
    @(negedge clk);
    check("resume_sel_adv", bus.sel, 1);
    check("resume_slot_end", bus.slot_end, 1'b1);

    // Data tracking on the selected channel
    bus.in[7:4] = 4'h5;
    @(negedge clk);
    check("track_out", bus.out, 4'h5);

    // Mid-slot reset while sel=2, prescaler at 2
    for (int i = 0; i < 20 && m_phase != 22; i++) @(negedge clk);
    check("pre_rst_sel", bus.sel, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_sel0", bus.sel, 0);
    check("midrst_an_n", bus.an_n, 3'b111);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_slot_len", bus.sel, 0);
    end
    @(negedge clk);
    check("midrst_next_sel", bus.sel, 1);

`ifdef SCAN_MUX_BLANK_EN
    // Blank channel 1: its slot shows nothing yet still lasts DIV cycles
    bus.blank = 3'b010;
    for (int i = 0; i < 20 && (m_phase % 12) != 3; i++) @(negedge clk);
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.sel == 1) begin
        hits++;
        check("blank_out", bus.out, 4'h0);
        check("blank_an_n", bus.an_n, 3'b111);
      end
    end
    check("blank_slot_len", hits, 4);
`else
    hits = 0;
    for (int i = 0; i < 4; i++) @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
